sysid_checker: RTL
==================

Name: sysid_checker

Overview:
- Avalon-MM read master that sits directly downstream of the system ID slave and consumes its `readdata`.
- After reset, or on request, it reads the ID word (address 0) and then the timestamp word (address 1).
- It compares both against build-time expected values and reports pass/fail, with captured values, to status logic or LEDs.
- Its purpose is to catch a mismatched FPGA image / software build before the CPU is released.

Parameters:
- EXPECTED_ID, 32'h00000000, required value at address 0
- EXPECTED_TS, 32'h513F9A6E (1363122798), required value at address 1
- READ_LATENCY, 0, cycles from accepted read to valid `readdata` (0–3)
- TIMEOUT_CYCLES, 255, max waitrequest stall cycles per read before abort (1–65535)
- AUTO_START, 1, 1 = start a check automatically on the first cycle after reset

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to run a check; ignored while `busy`
- avm_address  out  1  word address to the sysid slave
- avm_read  out  1  read strobe
- avm_waitrequest  in  1  slave stall; tie 0 for a zero-wait slave
- avm_readdata  in  32  read data from the slave
- busy  out  1  check in progress
- done  out  1  check finished; held until the next start
- pass  out  1  both words matched; valid when `done`
- id_mismatch  out  1  ID word differed from EXPECTED_ID
- ts_mismatch  out  1  timestamp word differed from EXPECTED_TS
- timeout  out  1  a read stalled longer than TIMEOUT_CYCLES
- id_value  out  32  captured ID word
- ts_value  out  32  captured timestamp word

Behaviour:
- One clock; reset is synchronous and active-high. All registers update on the rising edge of `clock`.
- Reset values:
  - State = IDLE.
  - `avm_read`, `avm_address`, `busy`, `done`, `pass`, all flags = 0.
  - `id_value`, `ts_value` = 0.
  - Stall and latency counters = 0.
- Reset asserted mid-check aborts immediately to reset values. No partial result is retained.
- States: IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, DONE.
- IDLE:
  - Go to ID_REQ on `start` = 1.
  - If AUTO_START = 1, also go to ID_REQ on the first cycle after `reset` falls, without `start`.
- Entering ID_REQ:
  - Clears `done`, `pass`, all flags and both captured values.
  - Sets `busy` = 1.
- ID_REQ / TS_REQ:
  - `avm_read` = 1; `avm_address` = 0 (ID) or 1 (TS). Both are registered and held stable while `avm_waitrequest` = 1.
  - A transfer is accepted on the cycle where `avm_read` = 1 and `avm_waitrequest` = 0. `avm_read` deasserts the next cycle.
  - Each stalled cycle increments the stall counter; the counter is cleared on acceptance.
  - If the counter reaches TIMEOUT_CYCLES with `avm_waitrequest` still 1: drop `avm_read`, set `timeout` = 1, go to DONE. `pass` stays 0.
- ID_WAIT / TS_WAIT:
  - Capture `avm_readdata` exactly READ_LATENCY cycles after acceptance.
  - With READ_LATENCY = 0, capture on the acceptance edge itself; the WAIT state is skipped, going REQ → next state directly.
  - After ID capture, go to TS_REQ. After TS capture, go to DONE.
- Mismatch flags are computed from the captured values with full 32-bit equality and registered with the capture.
- DONE:
  - `done` = 1; `busy` = 0.
  - `pass` = !`id_mismatch` & !`ts_mismatch` & !`timeout`.
  - Outputs are held indefinitely. `start` re-enters ID_REQ (a restart).
- `start` while `busy`: ignored, no effect on the sequence.
- `start` in the same cycle DONE is entered: ignored. It is only honoured from IDLE or DONE as the current state.
- No back-to-back reads: at least one cycle with `avm_read` = 0 separates the ID and TS reads.
- Best-case check duration, READ_LATENCY = 0, no stall:
  - `start` at cycle 0 → read ID at cycle 1 → read TS at cycle 3 → `done` = 1 at cycle 4.

Test Plan:
- Zero-wait slave returning 0 / 32'h513F9A6E, AUTO_START = 1, release `reset` → `done` = 1, `pass` = 1, `id_value` = 0, `ts_value` = 32'h513F9A6E, flags = 0, `done` rises 4 cycles after the first post-reset cycle.
- Slave timestamp 32'h513F9A6F → `ts_mismatch` = 1, `pass` = 0, `id_mismatch` = 0, `ts_value` = 32'h513F9A6F.
- `avm_waitrequest` held 1 forever, TIMEOUT_CYCLES = 8 → `avm_read` high exactly 8 cycles with `avm_address` = 0, then `timeout` = 1, `done` = 1, `pass` = 0.
- READ_LATENCY = 2, `avm_waitrequest` = 1 for 3 cycles on each read → `avm_address`/`avm_read` stable during the stall; data captured 2 cycles after acceptance; `pass` = 1.
- `start` pulsed while `busy` → no restart, single ID+TS pair on the bus. `start` pulsed in DONE → flags clear, check reruns, `pass` = 1.
- `reset` asserted during TS_WAIT → next cycle all outputs 0, `avm_read` = 0. With AUTO_START = 1, a fresh check runs after `reset` is released.

Source files
------------

// File: rtl/sysid_checker.sv
// sysid_checker: Avalon-MM read master that fetches the sysid ID and timestamp words
// and flags any mismatch against the build-time values before the CPU is released.
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'h00000000,
    parameter logic [31:0] EXPECTED_TS    = 32'h513F9A6E,
    parameter int          READ_LATENCY   = 0,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_mismatch,
    output logic        ts_mismatch,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);
    typedef enum logic [2:0] {IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, DONE} state_t;

    localparam bit          NO_WAIT    = READ_LATENCY == 0;
    localparam logic [1:0]  LAT_LAST   = 2'(NO_WAIT ? 0 : READ_LATENCY - 1);
    localparam logic [15:0] STALL_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] stall_q, stall_d;
    logic [1:0]  lat_q, lat_d;
    logic        auto_q, auto_d;
    logic        avm_read_q, avm_read_d;
    logic        avm_address_q, avm_address_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        id_mismatch_q, id_mismatch_d;
    logic        ts_mismatch_q, ts_mismatch_d;
    logic        timeout_q, timeout_d;
    logic [31:0] id_value_q, id_value_d;
    logic [31:0] ts_value_q, ts_value_d;

    logic accept, stall_hit, lat_done, launch, cap_id, cap_ts;

    assign accept    = avm_read_q & ~avm_waitrequest;
    assign stall_hit = avm_read_q & avm_waitrequest & (stall_q == STALL_LAST);
    assign lat_done  = lat_q == LAT_LAST;
    assign launch    = ((state_q == IDLE) & (start | auto_q)) | ((state_q == DONE) & start);
    // with zero latency the data is sampled on the acceptance edge and the WAIT state is skipped
    assign cap_id    = NO_WAIT ? (state_q == ID_REQ) & accept : (state_q == ID_WAIT) & lat_done;
    assign cap_ts    = NO_WAIT ? (state_q == TS_REQ) & accept : (state_q == TS_WAIT) & lat_done;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            stall_q       <= '0;
            lat_q         <= '0;
            auto_q        <= AUTO_START;
            avm_read_q    <= 1'b0;
            avm_address_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            id_mismatch_q <= 1'b0;
            ts_mismatch_q <= 1'b0;
            timeout_q     <= 1'b0;
            id_value_q    <= '0;
            ts_value_q    <= '0;
        end else begin
            state_q       <= state_d;
            stall_q       <= stall_d;
            lat_q         <= lat_d;
            auto_q        <= auto_d;
            avm_read_q    <= avm_read_d;
            avm_address_q <= avm_address_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            id_mismatch_q <= id_mismatch_d;
            ts_mismatch_q <= ts_mismatch_d;
            timeout_q     <= timeout_d;
            id_value_q    <= id_value_d;
            ts_value_q    <= ts_value_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = launch ? ID_REQ : state_q;
            ID_REQ:     state_d = stall_hit ? DONE : cap_id ? TS_REQ : accept ? ID_WAIT : ID_REQ;
            ID_WAIT:    state_d = cap_id ? TS_REQ : ID_WAIT;
            TS_REQ:     state_d = (stall_hit | cap_ts) ? DONE : accept ? TS_WAIT : TS_REQ;
            TS_WAIT:    state_d = cap_ts ? DONE : TS_WAIT;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        auto_d        = auto_q & ~launch;
        stall_d       = (avm_read_q & avm_waitrequest & ~stall_hit) ? stall_q + 16'd1 : 16'd0;
        lat_d         = ((state_q == ID_WAIT) | (state_q == TS_WAIT)) & ~lat_done ? lat_q + 2'd1 : 2'd0;
        // the TS strobe rises one cycle after entering TS_REQ, leaving an idle bus cycle between reads
        avm_read_d    = launch | (((state_q == ID_REQ) | (state_q == TS_REQ)) & ~accept & ~stall_hit);
        avm_address_d = (state_d == TS_REQ) | (state_d == TS_WAIT);
        busy_d        = (state_d != IDLE) & (state_d != DONE);
        done_d        = state_d == DONE;
        timeout_d     = launch ? 1'b0 : timeout_q | stall_hit;
        id_value_d    = launch ? 32'd0 : cap_id ? avm_readdata : id_value_q;
        ts_value_d    = launch ? 32'd0 : cap_ts ? avm_readdata : ts_value_q;
        id_mismatch_d = launch ? 1'b0 : cap_id ? avm_readdata != EXPECTED_ID : id_mismatch_q;
        ts_mismatch_d = launch ? 1'b0 : cap_ts ? avm_readdata != EXPECTED_TS : ts_mismatch_q;
        pass_d        = done_d & ~id_mismatch_d & ~ts_mismatch_d & ~timeout_d;
    end

    assign avm_read    = avm_read_q;
    assign avm_address = avm_address_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign id_mismatch = id_mismatch_q;
    assign ts_mismatch = ts_mismatch_q;
    assign timeout     = timeout_q;
    assign id_value    = id_value_q;
    assign ts_value    = ts_value_q;
endmodule
